// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: request/acknowledge bus master with byte lanes and load extension.
// Optional build macro MEM_MISALIGN_TRAP_EN: trap misaligned accesses instead of truncating them.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        sig_memread,
    input  logic        sig_memwrite,
    input  logic [2:0]  sig_memrdwidth,
    input  logic [1:0]  sig_memwrwidth,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misalign_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0] state;
    logic [2:0] rdwidth_q;
    logic [1:0] off_q;
    logic       is_read_q;
    logic       misalign_q;
    logic       mem_op;
    logic       trap;

    function automatic logic [3:0] store_strb(input logic [1:0] w, input logic [1:0] o);
        case (w)
            2'b00:   return 4'b0001 << o;
            2'b01:   return 4'b0011 << {o[1], 1'b0};
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] w, input logic [31:0] d);
        case (w)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Halfword offsets drop bit 0 and words ignore the offset, so misaligned
    // accesses read the aligned container when not trapped.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] o,
                                                 input logic [31:0] r);
        logic [1:0]  oe;
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   oe = o;
            2'b01:   oe = {o[1], 1'b0};
            default: oe = 2'b00;
        endcase
        w = r >> {oe, 3'b000};
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b100:  return {24'h0, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return r;
        endcase
    endfunction

`ifdef MEM_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic rd, input logic [2:0] rw,
                                           input logic [1:0] ww, input logic [1:0] o);
        logic [1:0] sz;
        sz = rd ? rw[1:0] : ww;
        return (sz == 2'b01 && o[0]) || (sz == 2'b10 && o != 2'b00);
    endfunction

    assign trap = is_misaligned(sig_memread, sig_memrdwidth, sig_memwrwidth, addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign mem_op       = sig_memread | sig_memwrite;
    assign stall        = mem_op & (state != S_DONE);
    assign misalign_err = misalign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            rdwidth_q  <= 3'b000;
            off_q      <= 2'b00;
            is_read_q  <= 1'b0;
            misalign_q <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'h0;
            bus_wdata  <= 32'h0;
            bus_wstrb  <= 4'h0;
            load_data  <= 32'h0;
            load_valid <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            misalign_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mem_op) begin
                        rdwidth_q <= sig_memrdwidth;
                        off_q     <= addr[1:0];
                        is_read_q <= sig_memread;
                        if (trap) begin
                            state      <= S_DONE;
                            misalign_q <= 1'b1;
                            load_data  <= 32'h0;
                        end else begin
                            state     <= S_REQ;
                            bus_req   <= 1'b1;
                            bus_we    <= ~sig_memread;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_wdata <= store_data(sig_memwrwidth, wdata);
                            bus_wstrb <= sig_memread ? 4'h0 : store_strb(sig_memwrwidth, addr[1:0]);
                        end
                    end
                end
                S_REQ: begin
                    if (bus_ack) begin
                        state     <= S_DONE;
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_wstrb <= 4'h0;
                        if (is_read_q) begin
                            load_data  <= load_extract(rdwidth_q, off_q, bus_rdata);
                            load_valid <= 1'b1;
                        end
                    end
                end
                // DONE lasts one cycle; the pipeline advances on this edge.
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with an arithmetic reference model and per-cycle compare.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        sig_memread, sig_memwrite;
    logic [2:0]  sig_memrdwidth;
    logic [1:0]  sig_memwrwidth;
    logic [31:0] addr, wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid, misalign_err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    mem_access_unit dut (
        .clk(clk), .rst(rst),
        .sig_memread(sig_memread), .sig_memwrite(sig_memwrite),
        .sig_memrdwidth(sig_memrdwidth), .sig_memwrwidth(sig_memwrwidth),
        .addr(addr), .wdata(wdata),
        .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .misalign_err(misalign_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Expectations for the current cycle, posted by the driver after each rising edge.
    bit          chk_en = 1'b0;
    bit          e_stall, e_req, e_we, e_lv, e_mis;
    logic [31:0] e_addr, e_wdata, e_ld;
    logic [3:0]  e_strb;
    logic [31:0] last_load = 32'h0;

    // Observations gathered while bus_req is high.
    int          req_cycles;
    logic [3:0]  saw_strb;
    logic [31:0] saw_wdata, saw_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_strb(input logic [1:0] w, input logic [31:0] a);
        int o;
        o = a % 4;
        if (w == 2'b00) return 4'(1 << o);
        if (w == 2'b01) return (o >= 2) ? 4'b1100 : 4'b0011;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] w, input logic [31:0] d);
        if (w == 2'b00) return (d & 32'hFF) * 32'h01010101;
        if (w == 2'b01) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] r);
        int o;
        logic [31:0] v;
        o = a % 4;
        if (f3 == 3'd1 || f3 == 3'd5) o = o - (o % 2);
        if (f3 == 3'd2) o = 0;
        v = r >> (8 * o);
        case (f3)
            3'd0:    return ((v & 32'hFF) >= 128) ? ((v & 32'hFF) | 32'hFFFFFF00) : (v & 32'hFF);
            3'd4:    return v & 32'hFF;
            3'd1:    return ((v & 32'hFFFF) >= 32768) ? ((v & 32'hFFFF) | 32'hFFFF0000) : (v & 32'hFFFF);
            3'd5:    return v & 32'hFFFF;
            default: return r;
        endcase
    endfunction

    function automatic bit m_trap(input bit rd, input logic [2:0] rw, input logic [1:0] ww,
                                  input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
        logic [1:0] sz;
        sz = rd ? rw[1:0] : ww;
        return (sz == 2'b01 && (a % 2) != 0) || (sz == 2'b10 && (a % 4) != 0);
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        if (bus_req) begin
            req_cycles++;
            saw_strb  = bus_wstrb;
            saw_wdata = bus_wdata;
            saw_addr  = bus_addr;
        end
        if (chk_en) begin
            check("stall", {31'h0, stall}, {31'h0, e_stall});
            check("bus_req", {31'h0, bus_req}, {31'h0, e_req});
            check("load_valid", {31'h0, load_valid}, {31'h0, e_lv});
            check("misalign_err", {31'h0, misalign_err}, {31'h0, e_mis});
            check("load_data", load_data, e_ld);
            if (e_req) begin
                check("bus_addr", bus_addr, e_addr);
                check("bus_we", {31'h0, bus_we}, {31'h0, e_we});
                check("bus_wstrb", {28'h0, bus_wstrb}, {28'h0, e_strb});
                if (e_we) check("bus_wdata", bus_wdata, e_wdata);
            end
        end
    end

    task automatic set_idle_exp();
        e_stall = 1'b0; e_req = 1'b0; e_lv = 1'b0; e_mis = 1'b0; e_ld = last_load;
    endtask

    // Issues one memory op visible from the current cycle; bus_ack arrives k cycles into REQ.
    task automatic run_op(input bit rd, input bit wr, input logic [2:0] rw, input logic [1:0] ww,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                          input int k);
        bit tr;
        tr = m_trap(rd, rw, ww, a);
        sig_memread = rd; sig_memwrite = wr; sig_memrdwidth = rw; sig_memwrwidth = ww;
        addr = a; wdata = wd; bus_ack = 1'b0;
        req_cycles = 0;
        e_addr = a - (a % 4);
        e_we = !rd;
        e_strb = rd ? 4'h0 : m_strb(ww, a);
        e_wdata = m_wdata(ww, wd);
        set_idle_exp();
        e_stall = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        if (tr) begin
            last_load = 32'h0;
            set_idle_exp();
            e_mis = 1'b1;
        end else begin
            for (int c = 1; c <= k; c++) begin
                e_req = 1'b1; e_stall = 1'b1;
                bus_ack = (c == k);
                bus_rdata = (c == k) ? word : ~word;
                @(posedge clk); #1;
            end
            bus_ack = 1'b0;
            if (rd) last_load = m_load(rw, a, word);
            set_idle_exp();
            e_lv = rd;
        end
        @(posedge clk); #1;
        sig_memread = 1'b0; sig_memwrite = 1'b0;
        set_idle_exp();
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        sig_memread = 1'b0; sig_memwrite = 1'b0; sig_memrdwidth = 3'b0; sig_memwrwidth = 2'b0;
        addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
        req_cycles = 0; saw_strb = 4'h0; saw_wdata = 32'h0; saw_addr = 32'h0;

        // Model pins against hand-computed values.
        check("pin_lb", m_load(3'd0, 32'h301, 32'h123480FF), 32'hFFFFFF80);
        check("pin_lbu", m_load(3'd4, 32'h301, 32'h123480FF), 32'h00000080);
        check("pin_lh", m_load(3'd1, 32'h402, 32'h80010000), 32'hFFFF8001);
        check("pin_sb_strb", {28'h0, m_strb(2'b00, 32'h203)}, 32'h8);

        @(posedge clk); #1;
        check("rst_bus_req", {31'h0, bus_req}, 32'h0);
        check("rst_bus_we", {31'h0, bus_we}, 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_bus_wstrb", {28'h0, bus_wstrb}, 32'h0);
        check("rst_load_data", load_data, 32'h0);
        check("rst_load_valid", {31'h0, load_valid}, 32'h0);
        check("rst_misalign", {31'h0, misalign_err}, 32'h0);
        check("rst_stall_idle", {31'h0, stall}, 32'h0);
        sig_memread = 1'b1; #1;
        check("rst_stall_follows", {31'h0, stall}, 32'h1);
        sig_memread = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(0, 1, 3'd0, 2'b10, 32'h104, 32'hDEADBEEF, 32'h0, 1);
        check("sw_strb", {28'h0, saw_strb}, 32'hF);
        check("sw_addr", saw_addr, 32'h104);
        check("sw_req_cycles", req_cycles, 1);

        run_op(0, 1, 3'd0, 2'b00, 32'h203, 32'h000000A5, 32'h0, 1);
        check("sb_strb", {28'h0, saw_strb}, 32'h8);
        check("sb_wdata", saw_wdata, 32'hA5A5A5A5);

        run_op(1, 0, 3'd0, 2'b00, 32'h301, 32'h0, 32'h123480FF, 1);
        check("lb_result", load_data, 32'hFFFFFF80);
        run_op(1, 0, 3'd4, 2'b00, 32'h301, 32'h0, 32'h123480FF, 2);
        check("lbu_result", load_data, 32'h00000080);

        run_op(1, 0, 3'd1, 2'b00, 32'h402, 32'h0, 32'h80010000, 4);
        check("lh_req_cycles", req_cycles, 4);
        check("lh_result", load_data, 32'hFFFF8001);

        run_op(0, 1, 3'd0, 2'b01, 32'h406, 32'h1234ABCD, 32'h0, 2);
        check("sh_strb", {28'h0, saw_strb}, 32'hC);
        check("sh_wdata", saw_wdata, 32'hABCDABCD);

        run_op(1, 0, 3'd5, 2'b00, 32'h400, 32'h0, 32'h0000F00D, 1);
        check("lhu_result", load_data, 32'h0000F00D);

        // Read wins when both requests are high.
        run_op(1, 1, 3'd4, 2'b10, 32'h700, 32'hFFFFFFFF, 32'h00000011, 1);
        check("rdwins_strb", {28'h0, saw_strb}, 32'h0);

        // Stray acknowledge while idle.
        set_idle_exp();
        bus_ack = 1'b1; bus_rdata = 32'h55555555;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a request.
        chk_en = 1'b0;
        sig_memread = 1'b1; sig_memrdwidth = 3'd2; addr = 32'h600;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_req_before", {31'h0, bus_req}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("mid_req_dropped", {31'h0, bus_req}, 32'h0);
        check("mid_req_stall", {31'h0, stall}, 32'h1);
        check("mid_req_ld", load_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_load = 32'h0;
        run_op(1, 0, 3'd2, 2'b00, 32'h600, 32'h0, 32'h89ABCDEF, 1);
        check("restart_lw", load_data, 32'h89ABCDEF);

        run_op(1, 0, 3'd2, 2'b00, 32'h502, 32'h0, 32'hCAFEF00D, 1);
`ifdef MEM_MISALIGN_TRAP_EN
        check("lw_mis_noreq", req_cycles, 0);
        check("lw_mis_ld", load_data, 32'h0);
`else
        check("lw_mis_addr", saw_addr, 32'h500);
        check("lw_mis_ld", load_data, 32'hCAFEF00D);
`endif

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
